// File: rtl/fsm_eg_stim_gen_pkg.sv
// Shared encodings for the stimulus generator and its target FSM.
// Control states, run commands and target state codes.
package fsm_eg_stim_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } ctl_t;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_S1   = 2'b01;
  localparam logic [1:0] CMD_S2   = 2'b11;
  localparam logic [1:0] CMD_BAD  = 2'b10;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b11
  } tgt_t;

endpackage

// File: rtl/fsm_eg_stim_gen_if.sv
// Lookup bus between the generator control and its sequence ROM.
// The master supplies {cmd, step}; the slave returns one step word.
interface fsm_eg_stim_gen_if;
  logic [1:0] cmd;
  logic [1:0] step;
  logic       a;
  logic       b;
  logic       exp_y0;
  logic       exp_y1;
  logic       last;

  modport master (
    output cmd, step,
    input  a, b, exp_y0, exp_y1, last
  );

  modport slave (
    input  cmd, step,
    output a, b, exp_y0, exp_y1, last
  );
endinterface

// File: rtl/fsm_eg_stim_rom.sv
// Combinational sequence table: {cmd, step} -> {a, b, y0, y1, last}.
// Unused slots and the illegal cmd return an empty terminal step.
module fsm_eg_stim_rom
  import fsm_eg_stim_gen_pkg::*;
(
  fsm_eg_stim_gen_if.slave rom
);

  logic [4:0] word;

  always_comb begin
    word = 5'b00001;
    unique case ({rom.cmd, rom.step})
      {CMD_IDLE, 2'd0}: word = 5'b00010;
      {CMD_IDLE, 2'd1}: word = 5'b00011;
      {CMD_S1,   2'd0}: word = 5'b10010;
      {CMD_S1,   2'd1}: word = 5'b00010;
      {CMD_S1,   2'd2}: word = 5'b10010;
      {CMD_S1,   2'd3}: word = 5'b00011;
      {CMD_S2,   2'd0}: word = 5'b11110;
      {CMD_S2,   2'd1}: word = 5'b00010;
      {CMD_S2,   2'd2}: word = 5'b00011;
      default:          word = 5'b00001;
    endcase
  end

  assign {rom.a, rom.b, rom.exp_y0, rom.exp_y1, rom.last} = word;

endmodule

// File: rtl/fsm_eg_stim_gen.sv
// Stimulus generator and checker for the 3-state example FSM.
// Runs a cmd-selected sequence, flags mismatches, counts failures.
module fsm_eg_stim_gen
  import fsm_eg_stim_gen_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  output logic             a,
  output logic             b,
  input  logic             y0,
  input  logic             y1,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  ctl_t       state, state_n;
  logic [1:0] cmd_q;
  logic [1:0] step;
  logic       run_err;
  logic       exp_y0, exp_y1, last_q;
  logic       mismatch;
  logic       accept;

  fsm_eg_stim_gen_if rom_bus ();

  fsm_eg_stim_rom u_rom (
    .rom (rom_bus.slave)
  );

  // Look one step ahead so a/b/expected are registered together
  assign rom_bus.cmd  = (state == IDLE) ? cmd : cmd_q;
  assign rom_bus.step = (state == IDLE) ? 2'd0 : step + 2'd1;

  assign accept   = (state == IDLE) && start;
  assign mismatch = (y0 != exp_y0) || (y1 != exp_y1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        ready = 1'b1;
        if (start)
          state_n = (cmd == CMD_BAD) ? FIN : RUN;
      end
      state == RUN: begin
        if (last_q) state_n = FIN;
      end
      state == FIN: begin
        done    = 1'b1;
        err     = run_err;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= CMD_IDLE;
      step    <= 2'd0;
      run_err <= 1'b0;
      a       <= 1'b0;
      b       <= 1'b0;
      exp_y0  <= 1'b0;
      exp_y1  <= 1'b0;
      last_q  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (accept) begin
        cmd_q   <= cmd;
        step    <= 2'd0;
        run_err <= (cmd == CMD_BAD);
        a       <= rom_bus.a;
        b       <= rom_bus.b;
        exp_y0  <= rom_bus.exp_y0;
        exp_y1  <= rom_bus.exp_y1;
        last_q  <= rom_bus.last;
      end else if (state == RUN) begin
        step    <= step + 2'd1;
        run_err <= run_err | mismatch;
        a       <= rom_bus.a & ~last_q;
        b       <= rom_bus.b & ~last_q;
        exp_y0  <= rom_bus.exp_y0;
        exp_y1  <= rom_bus.exp_y1;
        last_q  <= rom_bus.last;
      end else if (state == FIN) begin
        a <= 1'b0;
        b <= 1'b0;
        if (run_err && (err_cnt != '1))
          err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_eg_stim_gen.sv
// Randomised bench: generator drives a behavioural target FSM.
// Expected outputs come from sequence tables and the target rules.
module tb_fsm_eg_stim_gen;
  import fsm_eg_stim_gen_pkg::*;

  localparam int EW  = 2;
  localparam int SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic          a, b, y0, y1;
  logic          ready, done, err;
  logic [EW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  int len [4];
  int ab_tab [4][4];
  int y_tab [4][4];

  always #5 clk = ~clk;

  fsm_eg_stim_gen #(.ERR_W(EW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cmd     (cmd),
    .a       (a),
    .b       (b),
    .y0      (y0),
    .y1      (y1),
    .ready   (ready),
    .done    (done),
    .err     (err),
    .err_cnt (err_cnt)
  );

  fsm_eg_stim_gen_if rif ();
  fsm_eg_stim_rom u_rom (.rom(rif.slave));

  tgt_t ts;
  logic kill_y1 = 1'b0;

  always @(posedge clk) begin
    if (reset) ts <= S0;
    else begin
      case (ts)
        S0:      ts <= a ? (b ? S2 : S1) : S0;
        S1:      ts <= a ? S0 : S1;
        default: ts <= S0;
      endcase
    end
  end

  assign y1 = (ts != S2) && !kill_y1;
  assign y0 = (ts == S0) && a && b;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic run(input logic [1:0] c, input int fstep,
                     input int astep);
    int   n;
    int   w;
    logic mis;
    n   = len[c];
    mis = (c == CMD_BAD);
    w   = 0;
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", ready, 1);
    start = 1'b1;
    cmd   = c;
    @(negedge clk);
    start = 1'b0;
    cmd   = 2'($urandom);
    for (int k = 0; k < n; k++) begin
      kill_y1 = (k == fstep);
      chk("ab_step", {30'd0, a, b}, ab_tab[c][k]);
      chk("busy_ready", ready, 0);
      chk("busy_done", done, 0);
      if (k == astep) begin
        kill_y1 = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_ab", {30'd0, a, b}, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", err_cnt, 0);
        reset   = 1'b0;
        exp_cnt = 0;
        return;
      end
      #1;
      if ({30'd0, y0, y1} != y_tab[c][k]) mis = 1'b1;
      @(negedge clk);
    end
    kill_y1 = 1'b0;
    chk("fin_done", done, 1);
    chk("fin_err", err, mis);
    chk("fin_ab", {30'd0, a, b}, 0);
    chk("fin_ready", ready, 0);
    if (mis && exp_cnt < SAT) exp_cnt++;
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_ready", ready, 1);
    chk("err_cnt", err_cnt, exp_cnt);
  endtask

  initial begin
    int last_done;
    int ndone;
    len[CMD_IDLE] = 2;
    len[CMD_S1]   = 4;
    len[CMD_S2]   = 3;
    len[CMD_BAD]  = 0;
    ab_tab[CMD_IDLE] = '{0, 0, 0, 0};
    y_tab[CMD_IDLE]  = '{1, 1, 0, 0};
    ab_tab[CMD_S1]   = '{2, 0, 2, 0};
    y_tab[CMD_S1]    = '{1, 1, 1, 1};
    ab_tab[CMD_S2]   = '{3, 0, 0, 0};
    y_tab[CMD_S2]    = '{3, 1, 1, 0};
    ab_tab[CMD_BAD]  = '{0, 0, 0, 0};
    y_tab[CMD_BAD]   = '{0, 0, 0, 0};

    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < len[c]; s++) begin
        rif.cmd  = 2'(c);
        rif.step = 2'(s);
        #1;
        chk("rom_word", {27'd0, rif.a, rif.b, rif.exp_y0, rif.exp_y1,
             rif.last},
            (ab_tab[c][s] << 3) | (y_tab[c][s] << 1) |
            ((s == len[c] - 1) ? 1 : 0));
      end
    end
    rif.cmd  = CMD_BAD;
    rif.step = 2'd0;
    #1;
    chk("rom_bad", {27'd0, rif.a, rif.b, rif.exp_y0, rif.exp_y1,
         rif.last}, 1);

    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_ab", {30'd0, a, b}, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", err_cnt, 0);
    reset = 1'b0;
    @(negedge clk);

    run(CMD_S1, -1, -1);
    run(CMD_S2, -1, -1);
    run(CMD_BAD, -1, -1);
    run(CMD_IDLE, 1, -1);
    run(CMD_S1, -1, 2);
    for (int i = 0; i < 5; i++) run(CMD_BAD, -1, -1);
    chk("sat_cnt", err_cnt, SAT);

    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      logic [1:0] c;
      int         f;
      c = 2'($urandom_range(0, 3));
      f = -1;
      if (len[c] > 0 && $urandom_range(0, 3) == 0)
        f = $urandom_range(0, len[c] - 1);
      run(c, f, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    cmd       = CMD_IDLE;
    last_done = -1;
    ndone     = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) begin
        chk("hold_err", err, 0);
        if (last_done >= 0) chk("hold_period", t - last_done, 4);
        last_done = t;
        ndone++;
      end
    end
    start = 1'b0;
    chk("hold_runs", ndone, 10);
    chk("hold_cnt", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
